// File: rtl/cp0_exception_sequencer.sv
// cp0_exception_sequencer
//   Owns the single write port of CP0 (SR=12, Cause=13, EPC=14, PRId=15).
//   Arbitrates between pipeline mtc0 writes and hardware events (interrupts,
//   synchronous exceptions, eret). It walks the multi-cycle CP0 update for
//   each event, stalls the pipeline meanwhile, and finishes with a one-cycle
//   flush plus PC redirect.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-low reset
//   hw_int             level-sensitive interrupt requests (Cause/SR bits 15:10)
//   exc_req/exc_code   M-stage exception request and its ExcCode
//   exc_pc/exc_bd      PC of the M-stage instruction, branch-delay-slot flag
//   eret_req           M-stage eret
//   sw_we/addr/wdata   mtc0 write request from the pipeline
//   sr_value/epc_value current SR and EPC contents from CP0
//   cp0_we/addr/wdata  CP0 write port
//   stall              freeze the pipeline
//   flush, redirect    one-cycle pulses: kill in-flight work, load redirect_pc
//   redirect_pc        next fetch address
module cp0_exception_sequencer #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter int          NUM_HWINT  = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 exc_req,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          exc_pc,
    input  logic                 exc_bd,
    input  logic                 eret_req,
    input  logic                 sw_we,
    input  logic [4:0]           sw_addr,
    input  logic [31:0]          sw_wdata,
    input  logic [31:0]          sr_value,
    input  logic [31:0]          epc_value,
    output logic                 cp0_we,
    output logic [4:0]           cp0_addr,
    output logic [31:0]          cp0_wdata,
    output logic                 stall,
    output logic                 flush,
    output logic                 redirect,
    output logic [31:0]          redirect_pc
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_SR,
        JUMP,
        E_SR,
        E_JUMP
    } state_t;

    state_t               state;
    logic [4:0]           code_q;
    logic [31:0]          pc_q;
    logic                 bd_q;
    logic [NUM_HWINT-1:0] ip_q;
    logic                 exl_q;

    logic int_pend;
    logic trap_evt;

    // An interrupt is only taken when enabled (IE) and not already in EXL.
    assign int_pend = (|(hw_int & sr_value[10 +: NUM_HWINT])) & sr_value[0] & ~sr_value[1];
    assign trap_evt = int_pend | exc_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            code_q <= '0;
            pc_q   <= '0;
            bd_q   <= 1'b0;
            ip_q   <= '0;
            exl_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_evt) begin
                        // Interrupts carry ExcCode 0 and take over the
                        // M-stage instruction's PC/BD as the restart point.
                        code_q <= int_pend ? 5'd0 : exc_code;
                        pc_q   <= exc_pc;
                        bd_q   <= exc_bd;
                        ip_q   <= hw_int;
                        exl_q  <= sr_value[1];
                        // Nested exception: EPC must keep the outer return point.
                        state  <= sr_value[1] ? W_CAUSE : W_EPC;
                    end else if (eret_req) begin
                        state <= E_SR;
                    end
                end
                W_EPC:   state <= W_CAUSE;
                W_CAUSE: state <= W_SR;
                W_SR:    state <= JUMP;
                JUMP:    state <= IDLE;
                E_SR:    state <= E_JUMP;
                E_JUMP:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cp0_we      = 1'b0;
        cp0_addr    = 5'd0;
        cp0_wdata   = 32'd0;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (trap_evt || eret_req) begin
                        // Accept cycle: freeze now and drop any coincident mtc0.
                        stall = 1'b1;
                    end else begin
                        cp0_we    = sw_we;
                        cp0_addr  = sw_addr;
                        cp0_wdata = sw_wdata;
                    end
                end
                W_EPC: begin
                    stall     = 1'b1;
                    cp0_we    = 1'b1;
                    cp0_addr  = ADDR_EPC;
                    cp0_wdata = bd_q ? (pc_q - 32'd4) : pc_q;
                end
                W_CAUSE: begin
                    stall     = 1'b1;
                    cp0_we    = 1'b1;
                    cp0_addr  = ADDR_CAUSE;
                    // Under EXL the old BD cannot be read back, so BD is written as 0.
                    cp0_wdata = {bd_q & ~exl_q, 15'b0, ip_q, 3'b0, code_q, 2'b0};
                end
                W_SR: begin
                    stall     = 1'b1;
                    cp0_we    = 1'b1;
                    cp0_addr  = ADDR_SR;
                    cp0_wdata = sr_value | 32'h2;
                end
                JUMP: begin
                    stall       = 1'b1;
                    flush       = 1'b1;
                    redirect    = 1'b1;
                    redirect_pc = HANDLER_PC;
                end
                E_SR: begin
                    stall     = 1'b1;
                    cp0_we    = 1'b1;
                    cp0_addr  = ADDR_SR;
                    cp0_wdata = sr_value & ~32'h2;
                end
                E_JUMP: begin
                    stall       = 1'b1;
                    flush       = 1'b1;
                    redirect    = 1'b1;
                    redirect_pc = epc_value;
                end
                default: begin
                    stall = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_exception_sequencer.sv
// Testbench for cp0_exception_sequencer: directed steps with a per-cycle
// scoreboard of expected output vectors.
module tb_cp0_exception_sequencer;

    logic        clk;
    logic        reset;
    logic [5:0]  hw_int;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        eret_req;
    logic        sw_we;
    logic [4:0]  sw_addr;
    logic [31:0] sw_wdata;
    logic [31:0] sr_value;
    logic [31:0] epc_value;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        stall;
        logic        flush;
        logic        redirect;
        logic [31:0] rpc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    cp0_exception_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .hw_int      (hw_int),
        .exc_req     (exc_req),
        .exc_code    (exc_code),
        .exc_pc      (exc_pc),
        .exc_bd      (exc_bd),
        .eret_req    (eret_req),
        .sw_we       (sw_we),
        .sw_addr     (sw_addr),
        .sw_wdata    (sw_wdata),
        .sr_value    (sr_value),
        .epc_value   (epc_value),
        .cp0_we      (cp0_we),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cause_of(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] code);
        return {bd, 15'b0, ip, 3'b0, code, 2'b0};
    endfunction

    task automatic push(input logic we, input logic [4:0] a, input logic [31:0] d,
                        input logic st, input logic fl, input logic rd,
                        input logic [31:0] rpc);
        exp_t e;
        e.we = we; e.addr = a; e.wdata = d; e.stall = st;
        e.flush = fl; e.redirect = rd; e.rpc = rpc;
        exp_q.push_back(e);
    endtask

    task automatic push_quiet(input logic st);
        push(1'b0, 5'd0, 32'd0, st, 1'b0, 1'b0, 32'd0);
    endtask

    // Compare one cycle of DUT outputs on the falling edge, then advance to
    // just after the next rising edge where the next stimulus is applied.
    task automatic step(input string tag);
        exp_t e;
        exp_t o;
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, nothing to compare", tag);
        end else begin
            e = exp_q.pop_front();
            o = '{we: cp0_we, addr: cp0_addr, wdata: cp0_wdata, stall: stall,
                  flush: flush, redirect: redirect, rpc: redirect_pc};
            assert (o === e) else begin
                errors++;
                $error("FAIL %s: observed we=%b addr=%0d data=%h st=%b fl=%b rd=%b rpc=%h required we=%b addr=%0d data=%h st=%b fl=%b rd=%b rpc=%h",
                       tag, o.we, o.addr, o.wdata, o.stall, o.flush, o.redirect, o.rpc,
                       e.we, e.addr, e.wdata, e.stall, e.flush, e.redirect, e.rpc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        hw_int = 6'd0; exc_req = 1'b0; exc_code = 5'd0; exc_bd = 1'b0;
        eret_req = 1'b0; sw_we = 1'b0; sw_addr = 5'd0; sw_wdata = 32'd0;
    endtask

    initial begin
        clear_events();
        exc_pc = 32'd0; sr_value = 32'h0000_FC01; epc_value = 32'd0;
        reset = 1'b0;
        sw_we = 1'b1; sw_addr = 5'd12; sw_wdata = 32'h5;
        @(posedge clk);
        #1;
        // Reset state: outputs forced to 0 even with an mtc0 request present.
        push_quiet(1'b0); step("reset_gate0");
        push_quiet(1'b0); step("reset_gate1");
        reset = 1'b1;
        clear_events();
        push_quiet(1'b0); step("idle_quiet");

        // 1. Exception, EXL=0.
        sr_value = 32'h0000_FC01; exc_req = 1'b1; exc_code = 5'd4;
        exc_pc = 32'h3008; exc_bd = 1'b0;
        push_quiet(1'b1);
        push(1'b1, 5'd14, 32'h0000_3008, 1'b1, 1'b0, 1'b0, 32'd0);
        push(1'b1, 5'd13, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'd0);
        push(1'b1, 5'd12, 32'h0000_FC03, 1'b1, 1'b0, 1'b0, 32'd0);
        push(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0000_4180);
        step("t1_accept"); step("t1_epc"); step("t1_cause"); step("t1_sr"); step("t1_jump");
        clear_events();
        push_quiet(1'b0); step("t1_idle");

        // 2. Interrupt from a branch delay slot.
        hw_int = 6'b000100; exc_pc = 32'h3010; exc_bd = 1'b1;
        push_quiet(1'b1);
        push(1'b1, 5'd14, 32'h0000_300C, 1'b1, 1'b0, 1'b0, 32'd0);
        push(1'b1, 5'd13, 32'h8000_1000, 1'b1, 1'b0, 1'b0, 32'd0);
        push(1'b1, 5'd12, 32'h0000_FC03, 1'b1, 1'b0, 1'b0, 32'd0);
        push(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0000_4180);
        step("t2_accept"); step("t2_epc"); step("t2_cause"); step("t2_sr"); step("t2_jump");
        clear_events();
        push_quiet(1'b0); step("t2_idle");

        // 3. Interrupt beats exception and mtc0 in the same cycle.
        hw_int = 6'b000001; exc_req = 1'b1; exc_code = 5'd4;
        exc_pc = 32'h3040; exc_bd = 1'b0;
        sw_we = 1'b1; sw_addr = 5'd12; sw_wdata = 32'h0000_AAAA;
        push_quiet(1'b1);
        push(1'b1, 5'd14, 32'h0000_3040, 1'b1, 1'b0, 1'b0, 32'd0);
        push(1'b1, 5'd13, cause_of(1'b0, 6'b000001, 5'd0), 1'b1, 1'b0, 1'b0, 32'd0);
        push(1'b1, 5'd12, 32'h0000_FC03, 1'b1, 1'b0, 1'b0, 32'd0);
        push(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0000_4180);
        step("t3_accept");
        sw_we = 1'b0;
        step("t3_epc"); step("t3_cause"); step("t3_sr"); step("t3_jump");
        clear_events();
        push_quiet(1'b0); step("t3_idle");

        // 4. eret.
        sr_value = 32'h0000_FC03; epc_value = 32'h3020; eret_req = 1'b1;
        push_quiet(1'b1);
        push(1'b1, 5'd12, 32'h0000_FC01, 1'b1, 1'b0, 1'b0, 32'd0);
        push(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0000_3020);
        step("t4_accept"); step("t4_sr"); step("t4_jump");
        clear_events();
        push_quiet(1'b0); step("t4_idle");

        // 5. Nested exception under EXL; interrupt line must not be taken, BD written 0.
        sr_value = 32'h0000_FC03; hw_int = 6'b000001; exc_req = 1'b1;
        exc_code = 5'd12; exc_pc = 32'h3050; exc_bd = 1'b1;
        push_quiet(1'b1);
        push(1'b1, 5'd13, 32'h0000_0430, 1'b1, 1'b0, 1'b0, 32'd0);
        push(1'b1, 5'd12, 32'h0000_FC03, 1'b1, 1'b0, 1'b0, 32'd0);
        push(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0000_4180);
        step("t5_accept"); step("t5_cause"); step("t5_sr"); step("t5_jump");
        clear_events();
        push_quiet(1'b0); step("t5_idle");

        // EPC wrap: pc=0 in a delay slot.
        sr_value = 32'h0000_FC01; exc_req = 1'b1; exc_code = 5'd10;
        exc_pc = 32'h0; exc_bd = 1'b1;
        push_quiet(1'b1);
        push(1'b1, 5'd14, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'd0);
        push(1'b1, 5'd13, 32'h8000_0028, 1'b1, 1'b0, 1'b0, 32'd0);
        push(1'b1, 5'd12, 32'h0000_FC03, 1'b1, 1'b0, 1'b0, 32'd0);
        push(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0000_4180);
        step("wrap_accept"); step("wrap_epc"); step("wrap_cause"); step("wrap_sr"); step("wrap_jump");
        clear_events();

        // Idle mtc0 to read-only PRId is passed through.
        sw_we = 1'b1; sw_addr = 5'd15; sw_wdata = 32'hDEAD_BEEF;
        push(1'b1, 5'd15, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0);
        step("prid_pass");
        clear_events();

        // 6. Reset during W_CAUSE.
        exc_req = 1'b1; exc_code = 5'd4; exc_pc = 32'h3060; exc_bd = 1'b0;
        push_quiet(1'b1);
        push(1'b1, 5'd14, 32'h0000_3060, 1'b1, 1'b0, 1'b0, 32'd0);
        step("t6_accept"); step("t6_epc");
        reset = 1'b0;
        push_quiet(1'b0); step("t6_reset");
        reset = 1'b1;
        clear_events();
        sw_we = 1'b1; sw_addr = 5'd12; sw_wdata = 32'h1;
        push(1'b1, 5'd12, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'd0);
        step("t6_idle_sw");
        clear_events();
        push_quiet(1'b0); step("t6_quiet");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
